// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO pointer widths and Gray/binary conversion helpers
package fifo_pkg;
  localparam int ADDR_WIDTH_DEF = 3;
  typedef logic [31:0] word_t;
  function automatic int ptr_width(int aw);
    return aw + 1;
  endfunction
  function automatic word_t bin2gray(word_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic word_t gray2bin(word_t g);
    word_t b;
    b = g;
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if: write-side controller signals; W_AFULL exists only with FIFO_WR_AFULL_EN
interface fifo_wr_ctrl_if import fifo_pkg::*; #(parameter int ADDR_WIDTH = ADDR_WIDTH_DEF);
  localparam int PW = ptr_width(ADDR_WIDTH);
  logic                  W_INC;
  logic [PW-1:0]         RQ2_PTR;
  logic [ADDR_WIDTH-1:0] W_ADDR;
  logic [PW-1:0]         W_PTR;
  logic                  W_CLKEN;
  logic                  W_FULL;
  logic                  OVF_ERR;
`ifdef FIFO_WR_AFULL_EN
  logic                  W_AFULL;
  modport master (input W_INC, RQ2_PTR, output W_ADDR, W_PTR, W_CLKEN, W_FULL, OVF_ERR, W_AFULL);
  modport slave (output W_INC, RQ2_PTR, input W_ADDR, W_PTR, W_CLKEN, W_FULL, OVF_ERR, W_AFULL);
`else
  modport master (input W_INC, RQ2_PTR, output W_ADDR, W_PTR, W_CLKEN, W_FULL, OVF_ERR);
  modport slave (output W_INC, RQ2_PTR, input W_ADDR, W_PTR, W_CLKEN, W_FULL, OVF_ERR);
`endif
endinterface

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: converts a synchronized Gray pointer back to binary
module fifo_gray2bin import fifo_pkg::*; #(parameter int W = 4) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  assign bin = W'(gray2bin(word_t'(gray)));
endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write-pointer/full controller
// Define FIFO_WR_AFULL_EN to add the registered almost-full flag W_AFULL.
module fifo_wr_ctrl import fifo_pkg::*; #(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH = 2
) (
  input logic            CLK,
  input logic            RST,
  fifo_wr_ctrl_if.master wif
);
  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] MSB2 = {2'b11, {(PW-2){1'b0}}};
  if (AFULL_THRESH < 1 || AFULL_THRESH >= DEPTH) begin : g_bad_thresh
    $error("AFULL_THRESH out of range");
  end
  logic [PW-1:0] wbin, wbin_nxt, wgray_nxt;
  logic          full_nxt;
  // Full when the next write pointer has lapped the reader by exactly one depth
  always_comb begin
    wbin_nxt  = wbin + PW'(wif.W_INC & ~wif.W_FULL);
    wgray_nxt = PW'(bin2gray(word_t'(wbin_nxt)));
    full_nxt  = wgray_nxt == (wif.RQ2_PTR ^ MSB2);
  end
  assign wif.W_ADDR  = wbin[ADDR_WIDTH-1:0];
  assign wif.W_CLKEN = wif.W_INC & ~wif.W_FULL & ~RST;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wbin        <= '0;
      wif.W_PTR   <= '0;
      wif.W_FULL  <= 1'b0;
      wif.OVF_ERR <= 1'b0;
    end else begin
      wbin        <= wbin_nxt;
      wif.W_PTR   <= wgray_nxt;
      wif.W_FULL  <= full_nxt;
      wif.OVF_ERR <= wif.OVF_ERR | (wif.W_INC & wif.W_FULL);
    end
  end
`ifdef FIFO_WR_AFULL_EN
  localparam logic [PW-1:0] AFULL_LVL = PW'(DEPTH - AFULL_THRESH);
  logic [PW-1:0] rbin, level;
  fifo_gray2bin #(.W(PW)) u_g2b (.gray(wif.RQ2_PTR), .bin(rbin));
  assign level = wbin_nxt - rbin;
  always_ff @(posedge CLK) begin
    if (RST) wif.W_AFULL <= 1'b0;
    else wif.W_AFULL <= level >= AFULL_LVL;
  end
`endif
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: scoreboard bench for fifo_wr_ctrl with directed vectors
module tb_fifo_wr_ctrl;
  typedef struct {
    logic [3:0] ptr;
    logic [2:0] addr;
    logic       full;
    logic       ovf;
    logic       clken;
    logic       af;
    string      name;
  } exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t e;
  logic ck;
  logic [3:0] g [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                         4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  fifo_wr_ctrl_if #(.ADDR_WIDTH(3)) wif ();
  fifo_wr_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(2)) dut (.CLK(CLK), .RST(RST), .wif(wif));
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic step(input string nm, input logic rst, input logic inc, input logic [3:0] rq,
                      input logic [3:0] ptr, input logic [2:0] addr, input logic full,
                      input logic ovf, input logic clken, input logic af);
    exp_t x;
    @(posedge CLK);
    #2;
    RST = rst;
    wif.W_INC = inc;
    wif.RQ2_PTR = rq;
    x = '{ptr, addr, full, ovf, clken, af, nm};
    exp_q.push_back(x);
  endtask
  task automatic fill(input int n);
    for (int k = 1; k <= n; k++)
      step("fill", 1'b0, 1'b1, 4'd0, g[k], 3'(k), k == 8, 1'b0, 1'b1, k >= 6);
  endtask
  // Monitor: W_CLKEN is sampled mid-cycle, registered outputs just after the edge
  initial forever begin
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      ck = wif.W_CLKEN;
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk({e.name, ".clken"}, {3'b0, ck}, {3'b0, e.clken});
      chk({e.name, ".ptr"}, wif.W_PTR, e.ptr);
      chk({e.name, ".addr"}, {1'b0, wif.W_ADDR}, {1'b0, e.addr});
      chk({e.name, ".full"}, {3'b0, wif.W_FULL}, {3'b0, e.full});
      chk({e.name, ".ovf"}, {3'b0, wif.OVF_ERR}, {3'b0, e.ovf});
`ifdef FIFO_WR_AFULL_EN
      chk({e.name, ".afull"}, {3'b0, wif.W_AFULL}, {3'b0, e.af});
`endif
    end
  end
  initial begin
    wif.W_INC = 1'b0;
    wif.RQ2_PTR = 4'd0;
    step("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst_inc", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    fill(8);
    repeat (3) step("ovf", 0, 1, 0, 4'd12, 0, 1, 1, 0, 1);
    step("ovf_hold", 0, 0, 0, 4'd12, 0, 1, 1, 0, 1);
    step("rd1", 0, 0, 4'd1, 4'd12, 0, 0, 1, 0, 1);
    step("wr_after_rd", 0, 1, 4'd1, 4'd13, 3'd1, 1, 1, 1, 1);
    step("rst2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    fill(5);
    step("rst_mid", 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fill(7);
    step("same_cyc", 0, 1, 4'd1, 4'd12, 3'd0, 0, 0, 1, 1);
    step("same_cyc_full", 0, 1, 4'd1, 4'd13, 3'd1, 1, 0, 1, 1);
    step("full_hold", 0, 0, 4'd1, 4'd13, 3'd1, 1, 0, 0, 1);
    step("rst3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    fill(6);
    step("af_clr", 0, 0, 4'd1, 4'd5, 3'd6, 0, 0, 0, 0);
    step("rst4", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 16; k++)
      step("wrap", 1'b0, 1'b1, g[k-1], g[k%16], 3'(k), 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, FIFO address width; depth DEPTH = 2^ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1.
REQ-002 Parameter AFULL_THRESH, default 2, free-slot count at or below which W_AFULL asserts; legal range 1..DEPTH-1.
REQ-003 CLK  in  1  write-domain clock; one clock only, all state on rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 W_INC  in  1  write request for the current cycle.
REQ-006 RQ2_PTR  in  PW  read pointer, Gray-coded, already synchronized into CLK domain by the two-flop synchronizer.
REQ-007 W_ADDR  out  ADDR_WIDTH  memory write address, binary pointer LSBs.
REQ-008 W_PTR  out  PW  registered Gray write pointer, driven to the read-domain synchronizer.
REQ-009 W_CLKEN  out  1  memory write enable, combinational: W_INC & ~W_FULL.
REQ-010 W_FULL  out  1  registered full flag.
REQ-011 OVF_ERR  out  1  sticky overflow flag.
REQ-012 W_AFULL  out  1  registered almost-full flag; present only under the macro in REQ-027.

Function
REQ-013 Binary pointer wbin (PW bits) SHALL advance by 1 on a rising edge iff W_INC=1 and W_FULL=0; otherwise hold.
REQ-014 wbin wraps from 2^PW-1 to 0; W_ADDR = wbin[ADDR_WIDTH-1:0].
REQ-015 W_PTR SHALL be registered, equal to bin2gray(wbin) after every edge; only one bit changes per increment.
REQ-016 W_FULL next value = (gray of next wbin) equals RQ2_PTR with its two MSBs inverted and remaining bits unchanged.
REQ-017 W_FULL SHALL assert on the same edge as the write that fills the last slot; zero cycles of unprotected overrun.
REQ-018 W_FULL deassertion is pessimistic: it clears on the first edge after RQ2_PTR reflects a read; no early clear.
REQ-019 W_INC=1 while W_FULL=1: write dropped; pointers and W_FULL unchanged; OVF_ERR set on that edge.
REQ-020 OVF_ERR stays 1 until RST; W_INC never clears it.
REQ-021 RQ2_PTR changes and W_INC accepted in the same cycle: W_FULL is computed from the incremented pointer and the new RQ2_PTR together.
REQ-022 Pointer arithmetic is modulo 2^PW; no output is X for any RQ2_PTR value.

Reset
REQ-023 RST=1 at a rising edge: wbin=0, W_PTR=0, W_ADDR=0, W_FULL=0, OVF_ERR=0, W_AFULL=0.
REQ-024 RST wins over W_INC in the same cycle; the write is discarded.
REQ-025 RST mid-stream returns to the empty-pointer state in one edge; no other state survives.
REQ-026 W_CLKEN is 0 while RST=1.

Configuration
REQ-027 With macro FIFO_WR_AFULL_EN defined: RQ2_PTR is Gray-to-binary converted to rbin; level = (next wbin - rbin) mod 2^PW; W_AFULL registered = (level >= DEPTH - AFULL_THRESH).
REQ-028 Without FIFO_WR_AFULL_EN: port W_AFULL, rbin and level logic are absent; all other behaviour is identical.

Structure
REQ-029 Shared package fifo_pkg SHALL hold the default ADDR_WIDTH, the pointer-width derivation, and the bin2gray/gray2bin functions, shared with the read-side controller.
REQ-030 One sub-module, fifo_gray2bin, converts the synchronized Gray pointer; instantiated only under FIFO_WR_AFULL_EN.

Verification
REQ-031 RST, then 8 writes with RQ2_PTR=0 -> W_PTR sequence 1,3,2,6,7,5,4,12; W_FULL=1 on the 8th write edge; W_ADDR=0.
REQ-032 Full (W_PTR=4'b1100), W_INC=1 for 3 cycles -> W_PTR held, W_CLKEN=0, OVF_ERR=1 and stays 1.
REQ-033 Full, then RQ2_PTR 0->1 -> W_FULL=0 one edge later; next write gives W_PTR=13 and W_FULL=1.
REQ-034 16 writes, each with reads tracking via RQ2_PTR -> wbin wraps 15->0, W_PTR 8->0, W_FULL never asserts.
REQ-035 FIFO_WR_AFULL_EN defined, AFULL_THRESH=2, RQ2_PTR=0 -> W_AFULL=1 on the 6th write edge and 0 after RQ2_PTR=1.
REQ-036 RST asserted after 5 writes with W_INC=1 -> all outputs 0 after one edge; the write in the reset cycle is lost.
